serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request, sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  operation: 0 = A+B (carry chain), 1 = A-B (borrow chain).
REQ-006 SHALL have port a  input  WIDTH  operand A, latched with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, latched with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  WIDTH  sum or difference, held until the next completion.
REQ-011 SHALL have port cout  output  1  carry out for add, borrow out for subtract.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow, present only under ADDSUB_OVF_EN.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on the edge sampling start in IDLE, latch a, b, mode, clear the bit counter and clear the carry/borrow flop to 0.
REQ-015 SHALL process one bit per RUN cycle, LSB first, using a single-bit full-adder or full-subtractor cell with a registered carry/borrow.
REQ-016 Add bit: s = a^b^c, c' = ab | c(a^b); subtract bit: d = a^b^w, w' = (~a&b) | (~(a^b)&w).
REQ-017 SHALL collect bits in an internal shift register; result and cout SHALL update only on the edge entering DONE, never during RUN.
REQ-018 SHALL assert done during exactly the cycle in DONE, i.e. registered high on the WIDTH-th rising edge after the start-sampling edge.
REQ-019 SHALL ignore start while in RUN or DONE: no relatch, no restart, no change to counter or operands.
REQ-020 SHALL accept a new start in the IDLE cycle immediately following DONE; back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-021 SHALL ignore changes on a, b and mode after the start-sampling edge.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; cout is the carry/borrow out of bit WIDTH-1.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE and clear counter, carry flop, shift register, result, cout, ovf, done and busy to 0.
REQ-024 Reset mid-RUN SHALL abandon the operation with no done pulse; the first start after rst_n rises SHALL behave as a fresh operation.
REQ-025 Deassertion of rst_n SHALL be consumed on a rising clock edge; start is honoured no earlier than the first edge with rst_n high.

Configuration
REQ-026 Macro ADDSUB_OVF_EN defined: port ovf exists; ovf = carry/borrow into bit WIDTH-1 XOR cout, updated and held with result.
REQ-027 Macro ADDSUB_OVF_EN undefined: port ovf and all overflow logic are absent; all other behaviour is identical.

Verification (WIDTH=8, ADDSUB_OVF_EN defined)
REQ-028 Add 0x5A+0x33 -> result=0x8D, cout=0, ovf=1, with done on the 8th edge after start.
REQ-029 Subtract 0x05-0x07 -> result=0xFE, cout=1, ovf=0; subtract 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
REQ-030 Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0; a/b changed to 0x00 mid-RUN -> result unchanged.
REQ-031 Start pulsed at RUN cycles 3 and DONE -> single done pulse, result of first operation only; start in the following IDLE cycle -> accepted.
REQ-032 rst_n low at RUN cycle 4 -> busy=0, result=0, no done; next start with 0x10+0x01 -> result=0x11.

Source files
------------

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - request/result bundle for the bit-serial adder/subtractor
// The ovf member exists only when ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, mode, a, b,
    input  busy, done, result, cout
`ifdef ADDSUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cout
`ifdef ADDSUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - LSB-first bit-serial add/subtract, one bit per RUN cycle
// Optional signed overflow output under ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_addsub_if.slave    bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_c;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_done;
`ifdef ADDSUB_OVF_EN
  logic             r_ovf;
`endif

  logic             w_abit;
  logic             w_bbit;
  logic             w_s;
  logic             w_c_next;
  logic             w_last;
  logic [WIDTH-1:0] w_word;

  assign w_abit = r_acc[0];
  assign w_bbit = r_b[0];
  assign w_s    = w_abit ^ w_bbit ^ r_c;
  assign w_c_next = r_mode ? ((~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_c))
                           : ((w_abit & w_bbit) | (r_c & (w_abit ^ w_bbit)));
  assign w_last = (r_cnt == LAST_BIT);
  // r_acc shifts operand A out at the bottom while result bits enter at the top.
  assign w_word = {w_s, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_c      <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_done   <= 1'b0;
`ifdef ADDSUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= bus.a;
            r_b     <= bus.b;
            r_mode  <= bus.mode;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_word;
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_c_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= S_DONE;
            r_result <= w_word;
            r_cout   <= w_c_next;
            r_done   <= 1'b1;
`ifdef ADDSUB_OVF_EN
            // r_c here is the carry/borrow into the sign bit.
            r_ovf    <= r_c ^ w_c_next;
`endif
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
`ifdef ADDSUB_OVF_EN
  assign bus.ovf    = r_ovf;
`endif

endmodule
